// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared PWM constants and capture state encoding
package pwm_capture_pkg;
  localparam int NUM_W_DEF = 10;
  localparam int CNT_W_DEF = 16;
  localparam int TIMEOUT_DEF = 4096;
  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH, LOW} state_t;
endpackage

// File: rtl/pwm_capture_sync_edge.sv
// sync_edge: 2-flop synchroniser followed by a registered edge detector
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      level <= s2;
      rise <= s2 & ~level;
      fall <= ~s2 & level;
    end
  end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time, period and duty code with stuck-line timeout
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] period_len,
  output logic [NUM_W-1:0] number,
  output logic             period_ok,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] NSAT = CNT_W'((1 << NUM_W) - 1);
  localparam logic [CNT_W-1:0] PER = CNT_W'(1 << NUM_W);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic TO_OK = TIMEOUT == (1 << NUM_W);
  state_t state;
  logic level, rise, fall, edge_s, tout;
  logic [CNT_W-1:0] cnt, pend, idle;
  logic [1:0] warm;
  function automatic logic [NUM_W-1:0] to_num(input logic [CNT_W-1:0] h);
    return (h > NSAT) ? '1 : h[NUM_W-1:0];
  endfunction
  sync_edge u_sync (.clk(clk), .rst(rst), .d_in(pwm_in), .level(level), .rise(rise), .fall(fall));
  always_comb begin
    edge_s = rise | fall;
    tout = (idle == TO - 1'b1) && !edge_s;
  end
  // warm holds WAIT_LOW until the synchroniser has flushed its reset zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_LOW;
      cnt <= '0;
      pend <= '0;
      idle <= '0;
      warm <= '0;
      high_len <= '0;
      period_len <= '0;
      number <= '0;
      period_ok <= 1'b0;
      valid <= 1'b0;
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else begin
      valid <= 1'b0;
      warm <= warm + 2'(warm != 2'd3);
      idle <= edge_s ? '0 : (idle == TO ? idle : idle + 1'b1);
      cnt <= (cnt == CMAX) ? cnt : cnt + 1'b1;
      case (state)
        WAIT_LOW: if (warm == 2'd3 && !level) state <= WAIT_RISE;
        WAIT_RISE: if (rise) begin
          cnt <= CNT_W'(1);
          state <= HIGH;
        end
        HIGH: if (fall) begin
          pend <= cnt;
          state <= LOW;
        end else if (tout) begin
          high_len <= TO;
          period_len <= TO;
          number <= '1;
          period_ok <= TO_OK;
          valid <= 1'b1;
          stuck_hi <= 1'b1;
          state <= WAIT_LOW;
        end
        LOW: if (rise) begin
          high_len <= pend;
          period_len <= cnt;
          number <= to_num(pend);
          period_ok <= cnt == PER;
          valid <= 1'b1;
          stuck_hi <= 1'b0;
          stuck_lo <= 1'b0;
          cnt <= CNT_W'(1);
          state <= HIGH;
        end else if (tout) state <= WAIT_RISE;
        default: state <= WAIT_LOW;
      endcase
      if (tout && state != HIGH) begin
        high_len <= '0;
        period_len <= TO;
        number <= '0;
        period_ok <= TO_OK;
        valid <= 1'b1;
        stuck_lo <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: segment-level reference model feeding a scoreboard checked on valid
module tb_pwm_capture;
  logic clk = 1'b0, rst = 1'b0, pwm_in = 1'b0;
  logic [15:0] high_len, period_len;
  logic [9:0] number;
  logic period_ok, valid, stuck_hi, stuck_lo;
  pwm_capture dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_len(high_len), .period_len(period_len),
    .number(number), .period_ok(period_ok), .valid(valid), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  typedef struct {int hl; int pl; int num; bit ok; bit shi; bit slo; int c;} exp_t;
  exp_t q[$];
  // model state: 0 need low, 1 need rise, 2 in high, 3 in low
  int st = 1, cur_len = 0, prev_len = 0, hi_seg = 0;
  bit lvl = 1'b0, m_shi = 1'b0, m_slo = 1'b0;
  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    end
  endtask
  task automatic expect_res(input int hl, input int pl, input int c);
    exp_t e;
    e.hl = hl;
    e.pl = pl;
    e.num = hl > 1023 ? 1023 : hl;
    e.ok = pl == 1024;
    e.shi = m_shi;
    e.slo = m_slo;
    e.c = c;
    q.push_back(e);
  endtask
  task automatic seg(input bit v, input int n);
    int c;
    c = cyc;
    if (v != lvl) begin
      prev_len = cur_len;
      cur_len = n;
      if (v) begin
        if (st == 3) begin
          m_shi = 0;
          m_slo = 0;
          expect_res(hi_seg, hi_seg + prev_len, c + 4);
        end
        if (st == 1 || st == 3) st = 2;
      end else begin
        if (st == 2) begin
          hi_seg = prev_len;
          st = 3;
        end else if (st == 0) st = 1;
      end
    end else cur_len += n;
    lvl = v;
    pwm_in = v;
    if (n >= 5000) begin
      if (v && st == 2) begin
        m_shi = 1;
        expect_res(4096, 4096, -1);
        st = 0;
      end else if (v ? st == 0 : (st == 1 || st == 3)) begin
        m_slo = 1;
        expect_res(0, 4096, -1);
        if (!v) st = 1;
      end
    end
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_high_len", high_len, 0);
    chk("rst_period_len", period_len, 0);
    chk("rst_number", number, 0);
    chk("rst_period_ok", period_ok, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stuck_hi", stuck_hi, 0);
    chk("rst_stuck_lo", stuck_lo, 0);
    chk("rst_queue_empty", q.size(), 0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    st = lvl ? 0 : 1;
    m_shi = 0;
    m_slo = 0;
    cur_len = 0;
  endtask
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("high_len", high_len, e.hl);
        chk("period_len", period_len, e.pl);
        chk("number", number, e.num);
        chk("period_ok", period_ok, e.ok);
        chk("stuck_hi", stuck_hi, e.shi);
        chk("stuck_lo", stuck_lo, e.slo);
        if (e.c >= 0) chk("latency", cyc, e.c);
      end
    end
  end
  initial begin
    #2;
    do_reset();
    seg(0, 10);
    repeat (4) begin seg(1, 128); seg(0, 896); end
    repeat (3) begin seg(1, 1023); seg(0, 1); end
    repeat (3) begin seg(1, 1); seg(0, 1023); end
    seg(0, 5000);
    repeat (3) begin seg(1, 300); seg(0, 724); end
    seg(1, 5000);
    seg(0, 750);
    repeat (4) begin seg(1, 250); seg(0, 750); end
    seg(0, 100);
    seg(1, 60);
    do_reset();
    seg(1, 30);
    seg(0, 400);
    seg(1, 200);
    seg(0, 300);
    seg(1, 50);
    seg(0, 70);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(11, 0) == 0) seg(1'($urandom_range(1, 0)), 5000 + $urandom_range(500, 0));
      seg(1, $urandom_range(600, 1));
      seg(0, $urandom_range(600, 1));
    end
    seg(1, 20);
    seg(0, 20);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clk);
    chk("drain_queue", q.size(), 0);
    repeat (20) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
